odd_issue_sched: RTL and testbench



---
 rtl/odd_issue_sched.sv | 147 ++++++++++++++
 tb/tb_odd_issue_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/odd_issue_sched.sv
// Odd-pipe issue scheduler: shift-register scoreboard, RAW stall and operand forwarding selects.
// Optional saturating perf counters are enabled by defining ODD_SCHED_PERF_EN.
module odd_issue_sched #(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 7,
  parameter int LAT_BR   = 1,
  parameter int LAT_PERM = 3,
  parameter int LAT_LS   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_unit,
  input  logic              in_wr,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_ra,
  input  logic [ADDR_W-1:0] in_rb,
  input  logic [ADDR_W-1:0] in_rc,
  input  logic              in_use_ra,
  input  logic              in_use_rb,
  input  logic              in_use_rc,
  input  logic              flush,
  output logic              issue_valid,
  output logic [1:0]        issue_unit,
  output logic [3:0]        fwd_ra,
  output logic [3:0]        fwd_rb,
  output logic [3:0]        fwd_rc,
  output logic              stall
`ifdef ODD_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_issue
`endif
);

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [1:0]        unit;
    logic [ADDR_W-1:0] rt;
  } sb_entry_t;

  // r_sb[k-1] holds the instruction currently at stage k
  sb_entry_t r_sb [DEPTH];
  sb_entry_t w_stage1;

  logic [ADDR_W-1:0] w_src [3];
  logic [2:0]        w_use;
  logic [2:0]        w_haz;
  logic [3:0]        w_fwd [3];
  logic              w_hazard;
  logic              w_issue;

  function automatic logic [3:0] lat_of(input logic [1:0] u);
    case (u)
      2'd1:    lat_of = 4'(LAT_BR);
      2'd2:    lat_of = 4'(LAT_PERM);
      2'd3:    lat_of = 4'(LAT_LS);
      default: lat_of = 4'd0;
    endcase
  endfunction

  assign w_src[0] = in_ra;
  assign w_src[1] = in_rb;
  assign w_src[2] = in_rc;
  assign w_use    = {in_use_rc, in_use_rb, in_use_ra};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_op
      logic       w_hit;
      logic [3:0] w_k;
      logic [3:0] w_lat;
      // Scan oldest to youngest so the youngest match is the one left standing
      always_comb begin
        w_hit = 1'b0;
        w_k   = 4'd0;
        w_lat = 4'd0;
        for (int k = DEPTH; k >= 1; k--) begin
          if (r_sb[k-1].valid && r_sb[k-1].wr && (r_sb[k-1].rt == w_src[gi])) begin
            w_hit = 1'b1;
            w_k   = 4'(k);
            w_lat = lat_of(r_sb[k-1].unit);
          end
        end
      end
      assign w_haz[gi] = w_use[gi] & w_hit & (w_k < w_lat);
      assign w_fwd[gi] = (w_use[gi] & w_hit & ~w_haz[gi]) ? w_k : 4'd0;
    end
  endgenerate

  assign w_hazard    = |w_haz;
  assign w_issue     = ~reset & in_valid & ~w_hazard & ~flush;

  assign issue_valid = w_issue;
  assign issue_unit  = w_issue ? in_unit : 2'd0;
  assign in_ready    = reset | ~in_valid | w_issue | flush;
  assign stall       = ~reset & in_valid & w_hazard & ~flush;
  assign fwd_ra      = reset ? 4'd0 : w_fwd[0];
  assign fwd_rb      = reset ? 4'd0 : w_fwd[1];
  assign fwd_rc      = reset ? 4'd0 : w_fwd[2];

  // A nop still occupies its stage but can never be a forwarding source
  always_comb begin
    w_stage1       = '0;
    w_stage1.valid = w_issue;
    w_stage1.wr    = w_issue & in_wr & (in_unit != 2'd0);
    w_stage1.unit  = w_issue ? in_unit : 2'd0;
    w_stage1.rt    = w_issue ? in_rt : '0;
  end

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (reset) r_sb[gi] <= '0;
          else       r_sb[gi] <= w_stage1;
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (reset) r_sb[gi] <= '0;
          else       r_sb[gi] <= r_sb[gi-1];
        end
      end
    end
  endgenerate

`ifdef ODD_SCHED_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_issue;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_issue <= '0;
    end else begin
      if (stall && (r_perf_stall != '1))       r_perf_stall <= r_perf_stall + 32'd1;
      if (issue_valid && (r_perf_issue != '1)) r_perf_issue <= r_perf_issue + 32'd1;
    end
  end

  assign perf_stall = r_perf_stall;
  assign perf_issue = r_perf_issue;
`endif

endmodule

// File: tb/tb_odd_issue_sched.sv
// Directed self-checking bench for odd_issue_sched (define ODD_SCHED_PERF_EN to also check perf counters).
module tb_odd_issue_sched;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_unit;
  logic       in_wr;
  logic [6:0] in_rt, in_ra, in_rb, in_rc;
  logic       in_use_ra, in_use_rb, in_use_rc;
  logic       flush;
  logic       issue_valid;
  logic [1:0] issue_unit;
  logic [3:0] fwd_ra, fwd_rb, fwd_rc;
  logic       stall;
`ifdef ODD_SCHED_PERF_EN
  logic [31:0] perf_stall, perf_issue;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  odd_issue_sched dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_unit(in_unit), .in_wr(in_wr), .in_rt(in_rt), .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
    .in_use_ra(in_use_ra), .in_use_rb(in_use_rb), .in_use_rc(in_use_rc), .flush(flush),
    .issue_valid(issue_valid), .issue_unit(issue_unit),
    .fwd_ra(fwd_ra), .fwd_rb(fwd_rb), .fwd_rc(fwd_rc), .stall(stall)
`ifdef ODD_SCHED_PERF_EN
    , .perf_stall(perf_stall), .perf_issue(perf_issue)
`endif
  );

  // Advance one cycle; inputs are changed 1 time unit after the edge
  task automatic tick();
    if (issue_valid)
      $display("issue unit=%0d rt=%0d fwd=%0d/%0d/%0d", issue_unit, in_rt, fwd_ra, fwd_rb, fwd_rc);
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [1:0] unit, input logic wr, input logic [6:0] rt,
                         input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                         input logic ua, input logic ub, input logic uc);
    in_valid = 1'b1; in_unit = unit; in_wr = wr; in_rt = rt;
    in_ra = ra; in_rb = rb; in_rc = rc;
    in_use_ra = ua; in_use_rb = ub; in_use_rc = uc;
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_use_ra = 1'b0; in_use_rb = 1'b0; in_use_rc = 1'b0;
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (9) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    present(2'd2, 1'b1, 7'd1, 7'd1, 7'd2, 7'd3, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({in_ready, issue_valid, stall, issue_unit} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 10000", {in_ready, issue_valid, stall, issue_unit});
    end
    n_checks++;
    if ({fwd_ra, fwd_rb, fwd_rc} !== 12'h000) begin
      n_fail++; $display("FAIL reset_fwd: got %h want 000", {fwd_ra, fwd_rb, fwd_rc});
    end
    tick();
    reset = 1'b0;
    idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin
      present(2'd2, 1'b1, 7'(i), 7'(100 + i), 7'(110 + i), 7'(120 + i), 1'b1, 1'b1, 1'b1);
      n_checks++;
      if ({in_ready, issue_valid, stall, issue_unit} !== 5'b11010) begin
        n_fail++; $display("FAIL b2b_ctrl[%0d]: got %b want 11010", i, {in_ready, issue_valid, stall, issue_unit});
      end
      n_checks++;
      if ({fwd_ra, fwd_rb, fwd_rc} !== 12'h000) begin
        n_fail++; $display("FAIL b2b_fwd[%0d]: got %h want 000", i, {fwd_ra, fwd_rb, fwd_rc});
      end
      tick();
    end
    drain();
  endtask

  task automatic test_ls_dep();
    reset = 1'b1; idle(); tick(); reset = 1'b0;
    present(2'd3, 1'b1, 7'd5, 7'd50, 7'd51, 7'd52, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (issue_valid !== 1'b1) begin
      n_fail++; $display("FAIL ls_prod_issue: got %b want 1", issue_valid);
    end
    tick();
    present(2'd2, 1'b0, 7'd60, 7'd5, 7'd61, 7'd62, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      n_checks++;
      if ({in_ready, issue_valid, stall} !== 3'b001) begin
        n_fail++; $display("FAIL ls_stall[t+%0d]: got %b want 001", i, {in_ready, issue_valid, stall});
      end
      tick();
    end
    n_checks++;
    if ({issue_valid, stall, issue_unit, fwd_ra} !== {1'b1, 1'b0, 2'd2, 4'd6}) begin
      n_fail++; $display("FAIL ls_issue: got %b want 1010110", {issue_valid, stall, issue_unit, fwd_ra});
    end
    tick();
    idle();
`ifdef ODD_SCHED_PERF_EN
    n_checks++;
    if (perf_stall !== 32'd5) begin
      n_fail++; $display("FAIL perf_stall: got %0d want 5", perf_stall);
    end
    n_checks++;
    if (perf_issue !== 32'd2) begin
      n_fail++; $display("FAIL perf_issue: got %0d want 2", perf_issue);
    end
`endif
    drain();
  endtask

  task automatic test_perm_branch();
    present(2'd2, 1'b1, 7'd9, 7'd70, 7'd71, 7'd72, 1'b0, 1'b0, 1'b0);
    tick();
    present(2'd1, 1'b0, 7'd0, 7'd73, 7'd74, 7'd9, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 2; i++) begin
      n_checks++;
      if ({issue_valid, stall} !== 2'b01) begin
        n_fail++; $display("FAIL perm_stall[t+%0d]: got %b want 01", i, {issue_valid, stall});
      end
      tick();
    end
    n_checks++;
    if ({issue_valid, stall, issue_unit, fwd_rc} !== {1'b1, 1'b0, 2'd1, 4'd3}) begin
      n_fail++; $display("FAIL perm_issue: got %b want 1001 0011", {issue_valid, stall, issue_unit, fwd_rc});
    end
    tick();
    drain();
    present(2'd1, 1'b1, 7'd4, 7'd75, 7'd76, 7'd77, 1'b0, 1'b0, 1'b0);
    tick();
    present(2'd2, 1'b0, 7'd0, 7'd78, 7'd4, 7'd79, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({issue_valid, stall, fwd_rb} !== {1'b1, 1'b0, 4'd1}) begin
      n_fail++; $display("FAIL br_fwd1: got %b want 100001", {issue_valid, stall, fwd_rb});
    end
    tick();
    drain();
  endtask

  task automatic test_youngest();
    present(2'd3, 1'b1, 7'd2, 7'd80, 7'd81, 7'd82, 1'b0, 1'b0, 1'b0);
    tick();
    // nops naming rt=2 with wr set must not become forwarding sources
    for (int i = 1; i <= 3; i++) begin
      present(2'd0, 1'b1, 7'd2, 7'd83, 7'd84, 7'd85, 1'b0, 1'b0, 1'b0);
      tick();
    end
    present(2'd1, 1'b1, 7'd2, 7'd86, 7'd87, 7'd88, 1'b0, 1'b0, 1'b0);
    tick();
    present(2'd2, 1'b0, 7'd0, 7'd2, 7'd89, 7'd90, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({issue_valid, stall, fwd_ra} !== {1'b1, 1'b0, 4'd1}) begin
      n_fail++; $display("FAIL youngest: got %b want 100001", {issue_valid, stall, fwd_ra});
    end
    tick();
    drain();
    present(2'd2, 1'b1, 7'd20, 7'd91, 7'd92, 7'd93, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    repeat (7) tick();
    present(2'd1, 1'b0, 7'd0, 7'd20, 7'd94, 7'd95, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({issue_valid, fwd_ra} !== {1'b1, 4'd8}) begin
      n_fail++; $display("FAIL fwd_stage8: got %b want 11000", {issue_valid, fwd_ra});
    end
    tick();
    n_checks++;
    if ({issue_valid, fwd_ra} !== {1'b1, 4'd0}) begin
      n_fail++; $display("FAIL fwd_retired: got %b want 10000", {issue_valid, fwd_ra});
    end
    tick();
    drain();
  endtask

  task automatic test_flush();
    present(2'd2, 1'b1, 7'd30, 7'd96, 7'd97, 7'd98, 1'b0, 1'b0, 1'b0);
    tick();
    present(2'd1, 1'b1, 7'd31, 7'd30, 7'd99, 7'd99, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL flush_prestall: got %b want 1", stall);
    end
    flush = 1'b1; #1;
    n_checks++;
    if ({in_ready, issue_valid, stall, issue_unit} !== 5'b10000) begin
      n_fail++; $display("FAIL flush_ctrl: got %b want 10000", {in_ready, issue_valid, stall, issue_unit});
    end
    tick();
    flush = 1'b0;
    present(2'd2, 1'b0, 7'd0, 7'd99, 7'd31, 7'd99, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({issue_valid, fwd_rb} !== {1'b1, 4'd0}) begin
      n_fail++; $display("FAIL flush_bubble: got %b want 10000", {issue_valid, fwd_rb});
    end
    tick();
    drain();
  endtask

  task automatic test_reset_mid_stall();
    present(2'd3, 1'b1, 7'd40, 7'd100, 7'd101, 7'd102, 1'b0, 1'b0, 1'b0);
    tick();
    present(2'd2, 1'b0, 7'd0, 7'd40, 7'd103, 7'd104, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({in_ready, stall} !== 2'b01) begin
      n_fail++; $display("FAIL rst_prestall: got %b want 01", {in_ready, stall});
    end
    tick();
    reset = 1'b1; #1;
    n_checks++;
    if ({in_ready, issue_valid, stall, issue_unit, fwd_ra} !== 9'b100000000) begin
      n_fail++; $display("FAIL rst_mid: got %b want 100000000", {in_ready, issue_valid, stall, issue_unit, fwd_ra});
    end
    tick();
    reset = 1'b0; #1;
    n_checks++;
    if ({issue_valid, stall, fwd_ra} !== {1'b1, 1'b0, 4'd0}) begin
      n_fail++; $display("FAIL rst_after: got %b want 100000", {issue_valid, stall, fwd_ra});
    end
    tick();
    drain();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_unit = 2'd0; in_wr = 1'b0;
    in_rt = '0; in_ra = '0; in_rb = '0; in_rc = '0;
    in_use_ra = 1'b0; in_use_rb = 1'b0; in_use_rc = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_back_to_back();
    test_ls_dep();
    test_perm_branch();
    test_youngest();
    test_flush();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
